btn_event_decoder: RTL

//   Consumes the debounced button level from the anti-jitter stage and turns it into

---
 rtl/btn_event_decoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/btn_event_decoder.sv
// Button event decoder: resynchronises the debounced level and turns it
// into press/release, click, double-click, long-press and repeat pulses.
module btn_event_decoder #(
  parameter int CLK_PER_MS = 100000,
  parameter int LONG_MS    = 1000,
  parameter int DCLICK_MS  = 300,
  parameter int REPEAT_MS  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_ok,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int PW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_PER_MS - 1);
  localparam logic [15:0] T_LONG = 16'(LONG_MS);
  localparam logic [15:0] T_DCLK = 16'(DCLICK_MS);
  localparam logic [15:0] T_REP  = 16'(REPEAT_MS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  logic          r_s1;
  logic          r_s2;
  logic          r_btn_d;
  logic          r_press;
  logic          r_release;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_ms_cnt;
  state_t        r_state;
  logic          r_click;
  logic          r_dclick;
  logic          r_long;
  logic          r_rep;

  logic w_rise;
  logic w_fall;
  logic w_tick;

  assign w_rise = r_s2 & ~r_btn_d;
  assign w_fall = ~r_s2 & r_btn_d;
  assign w_tick = (r_presc == PMAX);

  assign held          = r_s2;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign click         = r_click;
  assign double_click  = r_dclick;
  assign long_press    = r_long;
  assign repeat_pulse  = r_rep;

  // btn_ok is from another clock domain: two flops before any use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_btn_d   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= btn_ok;
      r_s2      <= r_s1;
      r_btn_d   <= r_s2;
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Edges are tested before timeouts so a coincident timeout is dropped.
  // A transition below overrides the tick increment with a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ms_cnt <= '0;
      r_click  <= 1'b0;
      r_dclick <= 1'b0;
      r_long   <= 1'b0;
      r_rep    <= 1'b0;
    end else begin
      r_click  <= 1'b0;
      r_dclick <= 1'b0;
      r_long   <= 1'b0;
      r_rep    <= 1'b0;
      if (w_tick && (r_ms_cnt != 16'hFFFF)) begin
        r_ms_cnt <= r_ms_cnt + 16'd1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state  <= PRESS1;
            r_ms_cnt <= '0;
          end
        end
        PRESS1: begin
          if (w_fall) begin
            r_state  <= WAIT2;
            r_ms_cnt <= '0;
          end else if (r_ms_cnt == T_LONG) begin
            r_state  <= LONG;
            r_ms_cnt <= '0;
            r_long   <= 1'b1;
          end
        end
        WAIT2: begin
          if (w_rise) begin
            r_state  <= PRESS2;
            r_ms_cnt <= '0;
          end else if (r_ms_cnt == T_DCLK) begin
            r_state  <= IDLE;
            r_ms_cnt <= '0;
            r_click  <= 1'b1;
          end
        end
        PRESS2: begin
          if (w_fall) begin
            r_state  <= IDLE;
            r_ms_cnt <= '0;
            r_dclick <= 1'b1;
          end else if (r_ms_cnt == T_LONG) begin
            r_state  <= LONG;
            r_ms_cnt <= '0;
            r_long   <= 1'b1;
          end
        end
        LONG: begin
          if (w_fall) begin
            r_state  <= IDLE;
            r_ms_cnt <= '0;
          end else if (r_ms_cnt == T_REP) begin
            r_ms_cnt <= '0;
            r_rep    <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_ms_cnt <= '0;
        end
      endcase
    end
  end

endmodule
